fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Owns the architectural PC register and sequences instruction fetch for the single-issue core. It issues word requests to instruction memory, presents the fetched word to decode and next-PC logic, then commits the externally computed next PC. It also handles stalls, halt on an all-zero instruction, misaligned-target and fetch-timeout faults, and counts retired instructions.

Parameters:
RESET_VECTOR  32'h0000_0000  PC value loaded on reset
CNT_W         32             width of retired-instruction counter
MAX_WAIT      255            max cycles a fetch request may wait for imem_ready before a timeout fault (1..2^16-1)

Ports:
clk          in   1      system clock, rising edge
reset        in   1      synchronous, active-high reset
imem_req     out  1      instruction fetch request
imem_addr    out  32     fetch address (= pc while imem_req=1)
imem_ready   in   1      memory accepts request and returns data this cycle
imem_rdata   in   32     instruction word, valid when imem_ready=1
pc           out  32     current architectural PC
instr        out  32     registered instruction for decode/next-PC logic
instr_valid  out  1      instr/pc pair is valid for decode
next_pc_in   in   32     next PC computed combinationally from pc, instr, GPRs
stall        in   1      hazard stall; hold current instruction
resume       in   1      leave HALT; single-cycle pulse
halted       out  1      core halted
fault        out  2      00 none, 01 misaligned target, 10 fetch timeout
retired      out  CNT_W  count of committed instructions

Behaviour:
- Reset: pc=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0, halted=0, fault=00, retired=0, wait_cnt=0, state=FETCH. Reset mid-fetch drops imem_req at that edge. An imem_ready arriving in the reset cycle is ignored.
- States: FETCH, EXEC, HALT. All outputs are registered except imem_req and imem_addr, which are decoded from state: imem_req=1 iff state==FETCH, and imem_addr=pc.
- FETCH:
  - imem_req is held high until imem_ready; the request is never withdrawn.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, wait_cnt<=0, go EXEC. Minimum fetch latency is 1 cycle, with ready in the first request cycle.
  - Otherwise wait_cnt++. If wait_cnt reaches MAX_WAIT with no ready: fault<=10, halted<=1, go HALT, pc unchanged.
- EXEC (instr_valid=1). Priority is highest first:
  1. instr==32'h0: halted<=1, go HALT. pc is unchanged and retired is not incremented. This applies even if stall=1.
  2. stall=1: hold all state. instr and pc are stable.
  3. next_pc_in[1:0]!=00: fault<=01, halted<=1, go HALT. pc is unchanged and retired is not incremented.
  4. Otherwise: pc<=next_pc_in, retired<=retired+1 (wraps modulo 2^CNT_W), instr_valid<=0, go FETCH.
- Minimum instruction period is 2 cycles: FETCH with immediate ready, then EXEC without stall.
- HALT:
  - instr_valid<=0 on entry, imem_req=0, halted=1. stall is ignored.
  - resume=1: halted<=0, fault<=00, pc<=pc+4 (32-bit wrap), go FETCH.
  - The +4 skips the halting or faulting instruction. A timeout resume likewise skips the unreachable word.
  - resume in FETCH or EXEC is ignored.
- Simultaneous reset with any other input: reset wins.
- pc 32'hFFFF_FFFC plus 4 wraps to 0 on resume. next_pc_in wrap is the producer's responsibility.

Test Plan:
- Reset with RESET_VECTOR=32'h100, ready tied high, next_pc_in=pc+4, nonzero instrs -> imem_addr sequence 100,104,108, one new address every 2 cycles, retired increments by 1 per EXEC.
- imem_ready delayed 3 cycles -> imem_req and imem_addr=pc stay stable for all 4 cycles; instr_valid rises the cycle after ready; instr equals the imem_rdata sampled at ready.
- In EXEC, stall=1 for 5 cycles with next_pc_in=32'h200 -> pc and instr hold and retired is unchanged; on stall release pc=200 the next cycle and retired+1.
- Fetch returns 32'h0 while stall=1 -> HALT entered next cycle, halted=1, fault=00, pc unchanged; resume pulse -> pc=old+4, fetch restarts.
- next_pc_in=32'h0000_0102 -> fault=01, halted=1, pc unchanged; with MAX_WAIT=4 and ready held low -> fault=10 after 4 waiting cycles, imem_req=0.
- Assert reset during a pending fetch and with CNT_W=4 after 16 retirements -> imem_req=0 and pc=RESET_VECTOR next cycle; retired wraps 15->0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC and sequences single-issue
// instruction fetch. It requests a word from imem, holds it for decode
// while next_pc_in is computed, then commits the next PC. It halts on an
// all-zero instruction, on a misaligned target and on a fetch timeout.
// It also counts retired instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32,
  parameter int          MAX_WAIT     = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic [31:0]      next_pc_in,
  input  logic             stall,
  input  logic             resume,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  // Sequencer states
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  // Fault codes
  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_TIMEOUT  = 2'b10;

  // The wait counter is 16 bits wide, because MAX_WAIT is at most 2^16-1.
  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  logic [1:0]       state_q,   state_d;
  logic [31:0]      pc_q,      pc_d;
  logic [31:0]      instr_q,   instr_d;
  logic             valid_q,   valid_d;
  logic             halted_q,  halted_d;
  logic [1:0]       fault_q,   fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [15:0]      wait_q,    wait_d;
  logic [15:0]      wait_inc;
  // boot_q is set during reset and for the first cycle after it. In that
  // cycle no request is issued, so the edge that samples reset also drops
  // imem_req, even if the sequencer was fetching when reset arrived.
  logic             boot_q;
  logic             fetching;

  assign fetching    = (state_q == S_FETCH) && !boot_q;
  assign imem_req    = fetching;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

  assign wait_inc = wait_q + 16'd1;

  // Next-state logic for the FETCH / EXEC / HALT sequencing
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    wait_d    = wait_q;

    case (state_q)
      S_FETCH: begin
        if (!boot_q) begin
          if (imem_ready) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            wait_d  = 16'd0;
            state_d = S_EXEC;
          end else if (wait_inc == WAIT_LIMIT) begin
            // This is the MAX_WAIT-th cycle with no ready, so give up.
            // The PC is left pointing at the word that could not be fetched.
            fault_d  = F_TIMEOUT;
            halted_d = 1'b1;
            wait_d   = 16'd0;
            state_d  = S_HALT;
          end else begin
            wait_d = wait_inc;
          end
        end
      end

      S_EXEC: begin
        if (instr_q == 32'h0) begin
          // A zero word halts the core even when a stall is asserted.
          halted_d = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_HALT;
        end else if (stall) begin
          // Hold everything. Decode keeps seeing the same pc and instr.
          state_d = S_EXEC;
        end else if (next_pc_in[1:0] != 2'b00) begin
          fault_d  = F_MISALIGN;
          halted_d = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_HALT;
        end else begin
          pc_d      = next_pc_in;
          retired_d = retired_q + CNT_W'(1);
          valid_d   = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_HALT: begin
        if (resume) begin
          // Skip the word that caused the halt or fault.
          halted_d = 1'b0;
          fault_d  = F_NONE;
          pc_d     = pc_q + 32'd4;
          state_d  = S_FETCH;
        end
      end

      default: begin
        state_d  = S_FETCH;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        wait_d   = 16'd0;
      end
    endcase
  end

  // State registers. A synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    boot_q <= reset;
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'h0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= F_NONE;
      retired_q <= '0;
      wait_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed steps followed by a randomized
// stretch. Every cycle is checked against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h100;
  localparam int          CW = 4;
  localparam int          MW = 4;

  logic          clk = 1'b0;
  logic          reset, imem_ready, stall, resume;
  logic [31:0]   imem_rdata, next_pc_in;
  logic          imem_req, instr_valid, halted;
  logic [31:0]   imem_addr, pc, instr;
  logic [1:0]    fault;
  logic [CW-1:0] retired;

  fetch_sequencer #(.RESET_VECTOR(RV), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .next_pc_in(next_pc_in), .stall(stall),
    .resume(resume), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Model state: an instruction is either awaiting fetch, held for decode,
  // or the core is halted. The cycle after reset is quiet.
  logic [31:0]   m_pc, m_instr;
  bit            m_valid, m_halted, m_boot;
  logic [1:0]    m_fault;
  logic [CW-1:0] m_ret;
  int            m_waits;
  int            ncmp = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = RV; m_instr = 32'h0; m_valid = 0; m_halted = 0;
      m_fault = 2'b00; m_ret = '0; m_waits = 0; m_boot = 1;
    end else begin
      if (m_halted) begin
        if (resume) begin
          m_halted = 0; m_fault = 2'b00; m_pc = m_pc + 32'd4;
        end
      end else if (!m_valid) begin
        if (!m_boot) begin
          if (imem_ready) begin
            m_instr = imem_rdata; m_valid = 1; m_waits = 0;
          end else begin
            m_waits++;
            if (m_waits == MW) begin
              m_fault = 2'b10; m_halted = 1; m_waits = 0;
            end
          end
        end
      end else begin
        if (m_instr == 32'h0) begin
          m_halted = 1; m_valid = 0;
        end else if (!stall) begin
          if (next_pc_in[1:0] != 2'b00) begin
            m_fault = 2'b01; m_halted = 1; m_valid = 0;
          end else begin
            m_pc = next_pc_in; m_ret = m_ret + 1'b1; m_valid = 0;
          end
        end
      end
      m_boot = 0;
    end
  endtask

  task automatic check_all();
    chk("imem_req",    {31'b0, imem_req},    {31'b0, (!m_halted && !m_valid && !m_boot)});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("pc",          pc,                   m_pc);
    chk("instr",       instr,                m_instr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("halted",      {31'b0, halted},      {31'b0, m_halted});
    chk("fault",       {30'b0, fault},       {30'b0, m_fault});
    chk("retired",     {28'b0, retired},     {28'b0, m_ret});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; imem_ready = 0; stall = 0; resume = 0;
    imem_rdata = 32'h0; next_pc_in = 32'h0;
    m_boot = 1;

    // Reset
    tick(); tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    reset = 0;
    tick();
    chk("boot_addr", imem_addr, 32'h100);
    chk("boot_req", {31'b0, imem_req}, 32'd1);

    // Back-to-back instructions with ready tied high
    imem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      imem_rdata = $urandom | 32'h1;
      next_pc_in = m_pc + 32'd4;
      tick();
    end
    chk("seq_pc", pc, 32'h10C);
    chk("seq_ret", {28'b0, retired}, 32'd3);

    // Ready delayed by 3 cycles
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_addr", imem_addr, 32'h10C);
    end
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("dly_instr", instr, 32'hDEAD_BEEF);
    chk("dly_valid", {31'b0, instr_valid}, 32'd1);
    imem_ready = 0;

    // Stall in EXEC for 5 cycles
    stall = 1; next_pc_in = 32'h200;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_pc", pc, 32'h10C);
    chk("stall_ret", {28'b0, retired}, 32'd3);
    stall = 0;
    tick();
    chk("unstall_pc", pc, 32'h200);
    chk("unstall_ret", {28'b0, retired}, 32'd4);

    // A zero instruction halts even while stalled
    stall = 1; imem_ready = 1; imem_rdata = 32'h0;
    tick(); tick();
    chk("zero_halt", {31'b0, halted}, 32'd1);
    chk("zero_pc", pc, 32'h200);
    imem_ready = 0; stall = 0;
    tick();
    resume = 1; tick(); resume = 0;
    chk("resume_pc", pc, 32'h204);

    // Misaligned target
    imem_ready = 1; imem_rdata = 32'h13;
    tick();
    next_pc_in = 32'h0000_0102;
    tick();
    chk("mis_fault", {30'b0, fault}, 32'd1);
    chk("mis_pc", pc, 32'h204);
    resume = 1; tick(); resume = 0;

    // Fetch timeout after MAX_WAIT idle cycles
    imem_ready = 0;
    for (int i = 0; i < MW; i++) tick();
    chk("to_fault", {30'b0, fault}, 32'd2);
    chk("to_req", {31'b0, imem_req}, 32'd0);
    chk("to_pc", pc, 32'h208);
    resume = 1; tick(); resume = 0;

    // PC wraps from FFFF_FFFC to 0 on resume
    imem_ready = 1; imem_rdata = 32'h5;
    tick();
    next_pc_in = 32'hFFFF_FFFC;
    tick();
    imem_rdata = 32'h0;
    tick(); tick();
    imem_ready = 0;
    resume = 1; tick(); resume = 0;
    chk("wrap_pc", pc, 32'h0);

    // Randomized stretch
    for (int i = 0; i < 400; i++) begin
      int sel;
      reset      = ($urandom_range(0, 59) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      imem_rdata = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
      stall      = ($urandom_range(0, 9) < 3);
      resume     = ($urandom_range(0, 9) < 3);
      sel = $urandom_range(0, 9);
      if (sel < 7)      next_pc_in = m_pc + 32'd4;
      else if (sel < 9) next_pc_in = $urandom & 32'hFFFF_FFFC;
      else              next_pc_in = $urandom | 32'h1;
      tick();
    end

    // Reset during a pending fetch
    reset = 1; imem_ready = 0; stall = 0; resume = 0;
    tick();
    reset = 0;
    tick(); tick();
    chk("pend_req", {31'b0, imem_req}, 32'd1);
    reset = 1; imem_ready = 1;
    tick();
    chk("rst2_req", {31'b0, imem_req}, 32'd0);
    chk("rst2_pc", pc, 32'h100);
    reset = 0;
    tick();

    // 16 retirements wrap a 4-bit counter back to 0
    imem_ready = 1;
    for (int i = 0; i < 32; i++) begin
      imem_rdata = $urandom | 32'h1;
      next_pc_in = m_pc + 32'd4;
      tick();
    end
    chk("cnt_wrap", {28'b0, retired}, 32'd0);
    chk("cnt_pc", pc, 32'h140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
